// File: rtl/real_speed_to_step_clk_frequency.sv
// Speed (rev/s) to stepper step clock generator.
// Multiplies by steps/rev, divides clk freq by 2R, toggles step_clk.
module real_speed_to_step_clk_frequency #(
    parameter int unsigned CLK_FREQ_HZ   = 20_000_000,
    parameter int unsigned STEPS_PER_REV = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] real_speed,
    output logic        step_clk
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        LOAD = 2'd3
    } state_t;

    localparam logic [31:0] DIVIDEND  = 32'(CLK_FREQ_HZ);
    localparam logic [63:0] STEPS_64  = 64'(STEPS_PER_REV);

    state_t state_q;
    state_t state_d;

    logic [31:0] speed_reg;
    logic [63:0] product;
    logic [64:0] rem;
    logic [31:0] quot;
    logic [4:0]  iter;
    logic [31:0] active_h;
    logic [31:0] cnt;

    logic        change;
    logic        load_en;
    logic [65:0] rem_sh;
    logic [65:0] div_ext;
    logic [65:0] diff;
    logic        ge;
    logic [64:0] rem_nx;
    logic [31:0] quot_nx;
    logic [31:0] h_val;
    logic [32:0] cnt_inc;
    logic        hit;

    assign change = (real_speed != speed_reg);

    // Next-state logic; a speed change always restarts the pipeline.
    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        unique case (state_q)
            IDLE: if (change) state_d = MULT;
            MULT: state_d = DIV;
            DIV:  if (iter == 5'd31) state_d = LOAD;
            LOAD: begin
                state_d = IDLE;
                load_en = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (change) begin
            state_d = MULT;
            load_en = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // One restoring divider step: shift in next dividend bit, subtract if fits.
    always_comb begin
        rem_sh  = {rem, quot[31]};
        div_ext = {1'b0, product, 1'b0};
        ge      = (rem_sh >= div_ext);
        diff    = rem_sh - div_ext;
        rem_nx  = ge ? 65'(diff) : 65'(rem_sh);
        quot_nx = {quot[30:0], ge};
    end

    // Final half-period: 0 means stopped, a zero quotient clamps to 1.
    always_comb begin
        h_val = quot;
        if (product == 64'd0)   h_val = 32'd0;
        else if (quot == 32'd0) h_val = 32'd1;
    end

    // Capture, multiply, divide and load datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            speed_reg <= '0;
            product   <= '0;
            rem       <= '0;
            quot      <= '0;
            iter      <= '0;
            active_h  <= '0;
        end else begin
            if (change) speed_reg <= real_speed;
            if (state_q == MULT) begin
                product <= 64'(speed_reg) * STEPS_64;
                rem     <= '0;
                quot    <= DIVIDEND;
                iter    <= '0;
            end
            if (state_q == DIV) begin
                rem  <= rem_nx;
                quot <= quot_nx;
                iter <= iter + 5'd1;
            end
            if (load_en) active_h <= h_val;
        end
    end

    assign cnt_inc = {1'b0, cnt} + 33'd1;
    assign hit     = (cnt_inc >= {1'b0, active_h});

    // Toggle generator; a shorter new half-period fires on the next edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            step_clk <= 1'b0;
        end else if (active_h == 32'd0) begin
            cnt      <= '0;
            step_clk <= 1'b0;
        end else if (hit) begin
            cnt      <= '0;
            step_clk <= ~step_clk;
        end else begin
            cnt <= cnt_inc[31:0];
        end
    end

endmodule

// File: tb/tb_real_speed_to_step_clk_frequency.sv
// Directed bench for the speed to step clock converter.
// Measures half-periods of step_clk against hand-computed values.
module tb_real_speed_to_step_clk_frequency;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] real_speed = '0;
    logic        step_clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] speed;
        int          h;
    } vec_t;

    vec_t tbl[10];

    real_speed_to_step_clk_frequency #(
        .CLK_FREQ_HZ(20_000_000),
        .STEPS_PER_REV(200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .real_speed(real_speed),
        .step_clk(step_clk)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        n_vec++;
        if (act > lim) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected <= %0d", name, act, lim);
        end
    endtask

    // Cycles (negedge samples) until step_clk changes level, bounded.
    task automatic wait_toggle(input int limit, output int n);
        logic p;
        p = step_clk;
        n = 0;
        while (step_clk === p && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_toggles(input int cycles, output int t);
        logic p;
        t = 0;
        p = step_clk;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (step_clk !== p) t++;
            p = step_clk;
        end
    endtask

    // Align on a toggle, then check the next two half-periods.
    task automatic measure(input string name, input int h);
        int n, a, b;
        wait_toggle(2 * h + 8, n);
        wait_toggle(2 * h + 8, a);
        wait_toggle(2 * h + 8, b);
        check({name, " half0"}, a, h);
        check({name, " half1"}, b, h);
    endtask

    initial begin
        int n, t, prev, mx, k;

        tbl[0] = '{32'd1000,        50};
        tbl[1] = '{32'd2000,        25};
        tbl[2] = '{32'd333,        150};
        tbl[3] = '{32'd777,         64};
        tbl[4] = '{32'd500,        100};
        tbl[5] = '{32'd25000,        2};
        tbl[6] = '{32'd40000,        1};
        tbl[7] = '{32'd100000,       1};
        tbl[8] = '{32'hFFFF_FFFF,    1};
        tbl[9] = '{32'd0,            0};

        rst = 1'b0;
        real_speed = '0;
        repeat (2) @(negedge clk);
        check("reset_state", int'(step_clk), 0);
        rst = 1'b1;
        count_toggles(150, t);
        check("idle_no_toggle", t, 0);
        check("idle_level", int'(step_clk), 0);

        real_speed = 32'd1000;
        wait_toggle(200, n);
        check("first_toggle_latency", n, 85);
        measure("s1000_init", 50);
        prev = 50;

        for (int i = 0; i < 10; i++) begin
            real_speed = tbl[i].speed;
            repeat (40 + prev + tbl[i].h) @(negedge clk);
            if (tbl[i].h == 0) begin
                count_toggles(200, t);
                check($sformatf("vec%0d toggles", i), t, 0);
                check($sformatf("vec%0d level", i), int'(step_clk), 0);
            end else begin
                measure($sformatf("vec%0d", i), tbl[i].h);
            end
            prev = tbl[i].h;
        end

        real_speed = 32'd1000;
        repeat (40 + 50 + 50) @(negedge clk);
        real_speed = 32'd2000;
        mx = 0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            wait_toggle(120, n);
            if (n > mx) mx = n;
        end
        check_le("transition_max_half", mx, 50);
        check("transition_last_half", n, 25);

        real_speed = 32'd0;
        repeat (40 + 25) @(negedge clk);
        check("abort_pre_level", int'(step_clk), 0);
        real_speed = 32'd1000;
        repeat (10) @(negedge clk);
        real_speed = 32'd2000;
        wait_toggle(200, n);
        check("abort_first_toggle", n, 60);
        measure("abort", 25);

        real_speed = 32'hFFFF_FFFF;
        repeat (40 + 25 + 1) @(negedge clk);
        measure("max_rate", 1);
        real_speed = 32'd0;
        repeat (36) @(negedge clk);
        check("stop_within_36", int'(step_clk), 0);
        count_toggles(100, t);
        check("stop_stays_low", t, 0);

        real_speed = 32'd2000;
        repeat (40 + 25) @(negedge clk);
        k = 0;
        while (step_clk !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach_high", int'(step_clk), 1);
        rst = 1'b0;
        @(negedge clk);
        check("reset_mid", int'(step_clk), 0);
        @(negedge clk);
        rst = 1'b1;
        wait_toggle(200, n);
        check("reset_resume", n, 60);
        measure("resume", 25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
